// File: rtl/single_cycle_pkg.sv
// Shared definitions for the single_cycle RV32I core: opcodes, funct3 codes,
// the ALU operation set and the funct3/funct7 to ALU-op mapping.
package single_cycle_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load / store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // instruction[30] selects sub only in the register form (in OP-IMM it is
    // an immediate bit); for right shifts it selects arithmetic in both forms.
    function automatic alu_op_e alu_decode(input logic [2:0] f3,
                                           input logic       f7_alt,
                                           input logic       reg_form);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = (reg_form && f7_alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = f7_alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32 x XLEN integer register file: two combinational read ports, one write
// port. x0 always reads zero and ignores writes.
module register_file
    import single_cycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    output logic [XLEN-1:0]       rs1_data_o,
    output logic [XLEN-1:0]       rs2_data_o,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [XLEN-1:0]       rd_data_i
);

    logic [XLEN-1:0] data [0:NUM_REGS-1];

    // Register storage: cleared on reset, written on the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data[i] <= '0;
            end
        end else if (we_i && (rd_addr_i != '0)) begin
            data[rd_addr_i] <= rd_data_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == '0) ? '0 : data[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == '0) ? '0 : data[rs2_addr_i];

endmodule

// File: rtl/single_cycle.sv
// Single-cycle RV32I core. Decode, ALU, address generation and next-PC are
// combinational from the fetched instruction and the register file; the PC
// and the destination register update on the rising clock edge.
module single_cycle
    import single_cycle_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instructionAddress,
    output logic            data_rw,
    output logic [XLEN-1:0] dataAddress,
    inout  wire  [XLEN-1:0] data
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] immediate;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_b, alu_res;
    logic            br_taken;
    logic [XLEN-1:0] pc_plus4, mem_addr, load_val, store_val;
    logic            rd_we;
    logic [XLEN-1:0] rd_wdata;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];

    // Instruction class decode; malformed funct3 encodings fall back to NOP
    always_comb begin
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_opimm  = 1'b0;
        is_op     = 1'b0;
        case (opcode)
            OPC_LUI:    is_lui    = 1'b1;
            OPC_AUIPC:  is_auipc  = 1'b1;
            OPC_JAL:    is_jal    = 1'b1;
            OPC_JALR:   is_jalr   = (funct3 == 3'b000);
            OPC_BRANCH: is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            OPC_LOAD:   is_load   = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
            OPC_STORE:  is_store  = funct3 inside {F3_SB, F3_SH, F3_SW};
            OPC_OPIMM:  is_opimm  = 1'b1;
            OPC_OP:     is_op     = 1'b1;
            default:    ;
        endcase
    end

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                    instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};

    // Immediate selection by instruction format
    always_comb begin
        case (opcode)
            OPC_LUI, OPC_AUIPC: immediate = imm_u;
            OPC_JAL:            immediate = imm_j;
            OPC_BRANCH:         immediate = imm_b;
            OPC_STORE:          immediate = imm_s;
            default:            immediate = imm_i;
        endcase
    end

    register_file #(.XLEN(XLEN)) regFile (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr_i (rs1),
        .rs2_addr_i (rs2),
        .rs1_data_o (rs1_val),
        .rs2_data_o (rs2_val),
        .we_i       (rd_we),
        .rd_addr_i  (rd),
        .rd_data_i  (rd_wdata)
    );

    assign alu_op = alu_decode(funct3, instruction[30], is_op);
    assign alu_b  = is_op ? rs2_val : immediate;

    // Integer ALU shared by OP and OP-IMM
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_res = rs1_val + alu_b;
            ALU_SUB:  alu_res = rs1_val - alu_b;
            ALU_SLL:  alu_res = rs1_val << alu_b[4:0];
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(alu_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_val < alu_b)};
            ALU_XOR:  alu_res = rs1_val ^ alu_b;
            ALU_SRL:  alu_res = rs1_val >> alu_b[4:0];
            ALU_SRA:  alu_res = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
            ALU_OR:   alu_res = rs1_val | alu_b;
            default:  alu_res = rs1_val & alu_b;
        endcase
    end

    // Branch condition
    always_comb begin
        br_taken = 1'b0;
        if (is_branch) begin
            case (funct3)
                F3_BEQ:  br_taken = (rs1_val == rs2_val);
                F3_BNE:  br_taken = (rs1_val != rs2_val);
                F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
                F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
                F3_BLTU: br_taken = (rs1_val <  rs2_val);
                F3_BGEU: br_taken = (rs1_val >= rs2_val);
                default: br_taken = 1'b0;
            endcase
        end
    end

    assign pc_plus4 = pc_q + 32'd4;

    // Next-PC selection
    always_comb begin
        if (is_jal || br_taken) begin
            pc_d = pc_q + immediate;
        end else if (is_jalr) begin
            pc_d = (rs1_val + immediate) & ~32'd1;
        end else begin
            pc_d = pc_plus4;
        end
    end

    // Load data extraction from the low bits of the bus
    always_comb begin
        case (funct3)
            F3_LB:   load_val = {{24{data[7]}}, data[7:0]};
            F3_LH:   load_val = {{16{data[15]}}, data[15:0]};
            F3_LBU:  load_val = {24'h0, data[7:0]};
            F3_LHU:  load_val = {16'h0, data[15:0]};
            default: load_val = data;
        endcase
    end

    // Narrow stores are placed in the low bits with the rest zeroed
    always_comb begin
        case (funct3)
            F3_SB:   store_val = {24'h0, rs2_val[7:0]};
            F3_SH:   store_val = {16'h0, rs2_val[15:0]};
            default: store_val = rs2_val;
        endcase
    end

    // Write-back source selection
    always_comb begin
        rd_we    = 1'b0;
        rd_wdata = '0;
        if (is_lui) begin
            rd_we    = 1'b1;
            rd_wdata = immediate;
        end else if (is_auipc) begin
            rd_we    = 1'b1;
            rd_wdata = pc_q + immediate;
        end else if (is_jal || is_jalr) begin
            rd_we    = 1'b1;
            rd_wdata = pc_plus4;
        end else if (is_load) begin
            rd_we    = 1'b1;
            rd_wdata = load_val;
        end else if (is_opimm || is_op) begin
            rd_we    = 1'b1;
            rd_wdata = alu_res;
        end
    end

    assign mem_addr           = rs1_val + immediate;
    assign dataAddress        = (is_load || is_store) ? mem_addr : '0;
    assign data_rw            = rst_n && is_store;
    assign data               = data_rw ? store_val : {XLEN{1'bz}};
    assign instructionAddress = pc_q;

    // Program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_single_cycle.sv
// Bench for single_cycle: directed program fragments plus random instruction
// stream, with an instruction-level reference model feeding a scoreboard.
module tb_single_cycle;

    typedef struct packed {
        logic [31:0] pc;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] dat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [31:0] instructionAddress;
    logic        data_rw;
    logic [31:0] dataAddress;
    wire  [31:0] data;
    logic [31:0] bus_drv;
    logic        bus_en;

    int n_cmp;
    int n_bad;
    exp_t q[$];

    // reference model state
    logic [31:0] x [0:31];
    logic [31:0] mpc;
    exp_t        m_exp;

    localparam logic [31:0] FILL = 32'hC3C3_3C3C;

    assign data = bus_en ? bus_drv : 32'hzzzz_zzzz;

    single_cycle dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instruction        (instruction),
        .instructionAddress (instructionAddress),
        .data_rw            (data_rw),
        .dataAddress        (dataAddress),
        .data               (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) x[i] = 32'h0;
        mpc = 32'h0;
    endtask

    // Executes one instruction at architectural level; leaves the bus view
    // of this cycle in m_exp and advances registers and PC.
    task automatic model_step(input logic [31:0] ins, input logic [31:0] bus);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a, b, iI, iS, iB, iU, iJ, npc, val, opb;
        logic        wr, tk, alt;
        opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; alt = ins[30];
        a = x[ins[19:15]]; b = x[ins[24:20]];
        iI = 32'($signed(ins) >>> 20);
        iS = {iI[31:5], ins[11:7]};
        iB = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        iU = {ins[31:12], 12'h000};
        iJ = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        npc = mpc + 32'd4; wr = 1'b0; val = 32'h0; tk = 1'b0;
        m_exp.pc = mpc; m_exp.rw = 1'b0; m_exp.addr = 32'h0; m_exp.dat = bus;
        case (opc)
            7'h37: begin wr = 1'b1; val = iU; end
            7'h17: begin wr = 1'b1; val = mpc + iU; end
            7'h6F: begin wr = 1'b1; val = mpc + 32'd4; npc = mpc + iJ; end
            7'h67: if (f3 == 3'd0) begin
                wr = 1'b1; val = mpc + 32'd4; npc = (a + iI) & 32'hFFFF_FFFE;
            end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) npc = mpc + iB;
            end
            7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                m_exp.addr = a + iI; wr = 1'b1;
                case (f3)
                    3'd0: val = 32'($signed(bus[7:0]));
                    3'd1: val = 32'($signed(bus[15:0]));
                    3'd4: val = {24'h0, bus[7:0]};
                    3'd5: val = {16'h0, bus[15:0]};
                    default: val = bus;
                endcase
            end
            7'h23: if (f3 <= 3'd2) begin
                m_exp.rw = 1'b1; m_exp.addr = a + iS;
                m_exp.dat = (f3 == 3'd2) ? b : (f3 == 3'd1) ? (b & 32'h0000_FFFF) : (b & 32'h0000_00FF);
            end
            7'h13, 7'h33: begin
                wr  = 1'b1;
                opb = (opc == 7'h33) ? b : iI;
                case (f3)
                    3'd0: val = (opc == 7'h33 && alt) ? a - opb : a + opb;
                    3'd1: val = a << opb[4:0];
                    3'd2: val = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                    3'd3: val = (a < opb) ? 32'd1 : 32'd0;
                    3'd4: val = a ^ opb;
                    3'd5: val = alt ? 32'($signed(a) >>> opb[4:0]) : a >> opb[4:0];
                    3'd6: val = a | opb;
                    default: val = a & opb;
                endcase
            end
            default: ;
        endcase
        if (wr && rd != 5'd0) x[rd] = val;
        mpc = npc;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] bus, input logic rw);
        instruction = ins;
        bus_drv     = bus;
        bus_en      = !rw;
        @(posedge clk);
        #1;
    endtask

    // model-predicted expectation
    task automatic issue(input logic [31:0] ins, input logic [31:0] bus);
        model_step(ins, bus);
        q.push_back(m_exp);
        drive(ins, bus, m_exp.rw);
    endtask

    // hand-computed expectation; the model still steps to stay in sync
    task automatic issue_k(input logic [31:0] ins, input logic [31:0] bus, input logic [31:0] pc,
                           input logic rw, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        model_step(ins, bus);
        e.pc = pc; e.rw = rw; e.addr = addr; e.dat = rw ? wd : bus;
        q.push_back(e);
        drive(ins, bus, rw);
    endtask

    function automatic logic [31:0] gen_ins();
        logic [31:0] u;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          k;
        u  = $urandom();
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        k  = $urandom_range(0, 9);
        case (k)
            0: return {u[31:12], rd, 7'h37};
            1: return {u[31:12], rd, 7'h17};
            2: return {u[31:12], rd, 7'h6F};
            3: return {u[31:20], r1, 3'd0, rd, 7'h67};
            4: begin
                if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
                return {u[31:25], r2, r1, f3, u[11:7], 7'h63};
            end
            5: begin
                if (f3 == 3'd3 || f3 >= 3'd6) f3 = 3'd2;
                return {u[31:20], r1, f3, rd, 7'h03};
            end
            6: begin
                if (f3 > 3'd2) f3 = 3'd2;
                return {u[31:25], r2, r1, f3, u[11:7], 7'h23};
            end
            7: begin
                if (f3 == 3'd1) return {7'h00, u[24:20], r1, f3, rd, 7'h13};
                if (f3 == 3'd5) return {1'b0, u[30], 5'h00, u[24:20], r1, f3, rd, 7'h13};
                return {u[31:20], r1, f3, rd, 7'h13};
            end
            8: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && u[0]) ? 7'h20 : 7'h00;
                return {f7, r2, r1, f3, rd, 7'h33};
            end
            default: begin
                if (u[1:0] == 2'd0) return {u[31:7], 7'h0F};
                if (u[1:0] == 2'd1) return {u[31:7], 7'h73};
                return {u[31:7], 7'h7F};
            end
        endcase
    endfunction

    // Monitor: compares every presented cycle against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                check("pc", instructionAddress, e.pc);
                check("data_rw", {31'h0, data_rw}, {31'h0, e.rw});
                check("dataAddress", dataAddress, e.addr);
                check(e.rw ? "store_data" : "bus_released", data, e.dat);
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; instruction = 32'h0000_0013; bus_en = 1'b1; bus_drv = 32'hA5A5_5A5A;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check("reset_pc", instructionAddress, 32'h0);
        check("reset_rw", {31'h0, data_rw}, 32'h0);
        check("reset_addr", dataAddress, 32'h0);
        check("reset_bus", data, 32'hA5A5_5A5A);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // LED store via lui base
        issue_k(32'h0FF00493, FILL, 32'h00, 1'b0, 32'h0, 32'h0);          // addi x9,x0,255
        issue_k(32'h01500513, FILL, 32'h04, 1'b0, 32'h0, 32'h0);          // addi x10,x0,0x15
        issue_k(32'h400002B7, FILL, 32'h08, 1'b0, 32'h0, 32'h0);          // lui x5,0x40000
        issue_k(32'h00A28023, FILL, 32'h0C, 1'b1, 32'h4000_0000, 32'h15); // sb x10,0(x5)
        // stack push from sp=0
        issue_k(32'hFF410113, FILL, 32'h10, 1'b0, 32'h0, 32'h0);          // addi x2,x2,-12
        issue_k(32'h00000013, FILL, 32'h14, 1'b0, 32'h0, 32'h0);          // nop
        issue_k(32'h014000EF, FILL, 32'h18, 1'b0, 32'h0, 32'h0);          // jal x1,20
        issue_k(32'h00112223, FILL, 32'h2C, 1'b1, 32'hFFFF_FFF8, 32'h1C); // sw x1,4(x2)
        issue_k(32'h00412083, 32'h1C, 32'h30, 1'b0, 32'hFFFF_FFF8, 32'h0); // lw x1,4(x2)
        issue_k(32'h00008067, FILL, 32'h34, 1'b0, 32'h0, 32'h0);          // jalr x0,x1,0
        issue_k(32'h00100513, FILL, 32'h1C, 1'b0, 32'h0, 32'h0);          // addi x10,x0,1
        issue_k(32'hFE954AE3, FILL, 32'h20, 1'b0, 32'h0, 32'h0);          // blt x10,x9,-12 taken
        issue_k(32'h17900513, FILL, 32'h14, 1'b0, 32'h0, 32'h0);          // addi x10,x0,377
        issue_k(32'h00500013, FILL, 32'h18, 1'b0, 32'h0, 32'h0);          // addi x0,x0,5
        issue_k(32'h00000013, FILL, 32'h1C, 1'b0, 32'h0, 32'h0);          // nop
        issue_k(32'hFE954AE3, FILL, 32'h20, 1'b0, 32'h0, 32'h0);          // blt not taken
        issue_k(32'h00002023, FILL, 32'h24, 1'b1, 32'h0, 32'h0);          // sw x0,0(x0)
        // ALU corners
        issue_k(32'h00100313, FILL, 32'h28, 1'b0, 32'h0, 32'h0);          // addi x6,x0,1
        issue_k(32'hFFF00393, FILL, 32'h2C, 1'b0, 32'h0, 32'h0);          // addi x7,x0,-1
        issue_k(32'h406005B3, FILL, 32'h30, 1'b0, 32'h0, 32'h0);          // sub x11,x0,x6
        issue_k(32'h0063A633, FILL, 32'h34, 1'b0, 32'h0, 32'h0);          // slt x12,x7,x6
        issue_k(32'h0063B6B3, FILL, 32'h38, 1'b0, 32'h0, 32'h0);          // sltu x13,x7,x6
        issue_k(32'h80000737, FILL, 32'h3C, 1'b0, 32'h0, 32'h0);          // lui x14,0x80000
        issue_k(32'h40475793, FILL, 32'h40, 1'b0, 32'h0, 32'h0);          // srai x15,x14,4
        issue_k(32'h00B02023, FILL, 32'h44, 1'b1, 32'h0, 32'hFFFF_FFFF);  // sw x11
        issue_k(32'h00C02023, FILL, 32'h48, 1'b1, 32'h0, 32'h1);          // sw x12
        issue_k(32'h00D02023, FILL, 32'h4C, 1'b1, 32'h0, 32'h0);          // sw x13
        issue_k(32'h00F02023, FILL, 32'h50, 1'b1, 32'h0, 32'hF800_0000);  // sw x15
        issue_k(32'h00701123, FILL, 32'h54, 1'b1, 32'h2, 32'h0000_FFFF);  // sh x7,2(x0)
        issue_k(32'h00A000A3, FILL, 32'h58, 1'b1, 32'h1, 32'h79);         // sb x10,1(x0)
        issue_k(32'h00000803, 32'hF0, 32'h5C, 1'b0, 32'h0, 32'h0);        // lb x16,0(x0)
        issue_k(32'h01002023, FILL, 32'h60, 1'b1, 32'h0, 32'hFFFF_FFF0);  // sw x16

        // random instruction stream
        for (int i = 0; i < 600; i++) begin
            issue(gen_ins(), $urandom());
        end
        // expose registers through stores
        for (int r = 1; r < 8; r++) begin
            issue({7'h00, 5'(r), 5'd0, 3'd2, 5'd0, 7'h23}, FILL);
        end

        // reset asserted in the middle of a cycle while a store is presented
        instruction = 32'h00B02023;
        bus_en  = 1'b1;
        bus_drv = FILL;
        rst_n   = 1'b0;
        #1;
        check("midreset_pc", instructionAddress, 32'h0);
        check("midreset_rw", {31'h0, data_rw}, 32'h0);
        check("midreset_bus", data, FILL);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 1; r < 8; r++) begin
            issue({7'h00, 5'(r), 5'd0, 3'd2, 5'd0, 7'h23}, FILL);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
